pds_bus_sync: RTL and testbench



---
 rtl/pds_bus_sync_if.sv | 32 +++
 rtl/pds_bus_sync.sv | 116 +++++++++++
 tb/tb_pds_bus_sync.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pds_bus_sync_if.sv
// PDS bus signal bundle between the asynchronous PDS side, the 68030 address strobe
// and the synchronized outputs consumed by the bus sequencer.
interface pds_bus_sync_if;
    logic       pdsC8m;
    logic       pdsClockE;
    logic       npdsDtack;
    logic       npdsVpa;
    logic       ncpuAS;

    logic       c8mSync;
    logic       c8mRise;
    logic       c8mFall;
    logic       eSync;
    logic [3:0] ePhase;
    logic       eLocked;
    logic       eRiseNext;
    logic       dtackSampled;
    logic       vpaSampled;
    logic       busTimeout;

    modport master (
        output pdsC8m, pdsClockE, npdsDtack, npdsVpa, ncpuAS,
        input  c8mSync, c8mRise, c8mFall, eSync, ePhase, eLocked, eRiseNext,
               dtackSampled, vpaSampled, busTimeout
    );

    modport slave (
        input  pdsC8m, pdsClockE, npdsDtack, npdsVpa, ncpuAS,
        output c8mSync, c8mRise, c8mFall, eSync, ePhase, eLocked, eRiseNext,
               dtackSampled, vpaSampled, busTimeout
    );
endinterface

// File: rtl/pds_bus_sync.sv
// Front-end of the PDS bus sequencer: synchronizes C8M/E/DTACK/VPA into cpuClock,
// derives C8M edge strobes, tracks E-clock phase and runs the bus-timeout watchdog.
module pds_bus_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int E_PERIOD    = 10,
    parameter int TIMEOUT_C8M = 200
) (
    input  logic          cpuClock,
    input  logic          pdsReset,
    pds_bus_sync_if.slave bus
);
    localparam logic [3:0] PHASE_LO = 4'(E_PERIOD - 1);
    localparam logic [3:0] PHASE_HI = 4'(E_PERIOD);
    localparam logic [3:0] PHASE_MAX = 4'hF;
    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT_C8M);
    localparam logic [7:0] WD_LAST  = 8'(TIMEOUT_C8M - 1);

    logic [SYNC_STAGES-1:0] c8m_sr, e_sr, dtack_sr, vpa_sr;
    logic                   c8m_prev, e_prev;
    logic                   c8m_rise_q, c8m_fall_q;
    logic [3:0]             e_phase, e_phase_nxt;
    logic                   e_locked, e_locked_nxt, e_rise_next;
    logic                   dtack_q, vpa_q;
    logic [7:0]             wd_count;
    logic                   timeout_q;

    logic c8m_sync, e_sync, dtack_n_sync, vpa_n_sync;
    logic c8m_rise, c8m_fall, e_rise;

    assign c8m_sync     = c8m_sr[SYNC_STAGES-1];
    assign e_sync       = e_sr[SYNC_STAGES-1];
    assign dtack_n_sync = dtack_sr[SYNC_STAGES-1];
    assign vpa_n_sync   = vpa_sr[SYNC_STAGES-1];

    // Edge events taken one stage behind the sync output so C8M and E line up exactly.
    assign c8m_rise = c8m_sync & ~c8m_prev;
    assign c8m_fall = ~c8m_sync & c8m_prev;
    assign e_rise   = e_sync & ~e_prev;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        e_phase_nxt  = e_phase;
        e_locked_nxt = e_locked;
        if (e_rise) begin
            e_phase_nxt  = '0;
            e_locked_nxt = (e_phase == PHASE_LO) || (e_phase == PHASE_HI);
        end else if (c8m_rise && (e_phase != PHASE_MAX)) begin
            e_phase_nxt = e_phase + 4'd1;
        end
        if (!e_rise && (e_phase_nxt == PHASE_MAX)) begin
            e_locked_nxt = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge cpuClock) begin
        if (pdsReset) begin
            c8m_sr      <= '0;
            e_sr        <= '0;
            dtack_sr    <= '1;
            vpa_sr      <= '1;
            c8m_prev    <= 1'b0;
            e_prev      <= 1'b0;
            c8m_rise_q  <= 1'b0;
            c8m_fall_q  <= 1'b0;
            e_phase     <= '0;
            e_locked    <= 1'b0;
            e_rise_next <= 1'b0;
            dtack_q     <= 1'b0;
            vpa_q       <= 1'b0;
            wd_count    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            c8m_sr   <= {c8m_sr[SYNC_STAGES-2:0], bus.pdsC8m};
            e_sr     <= {e_sr[SYNC_STAGES-2:0], bus.pdsClockE};
            dtack_sr <= {dtack_sr[SYNC_STAGES-2:0], bus.npdsDtack};
            vpa_sr   <= {vpa_sr[SYNC_STAGES-2:0], bus.npdsVpa};
            c8m_prev <= c8m_sync;
            e_prev   <= e_sync;

            c8m_rise_q  <= c8m_rise;
            c8m_fall_q  <= c8m_fall;
            e_phase     <= e_phase_nxt;
            e_locked    <= e_locked_nxt;
            e_rise_next <= e_locked_nxt && (e_phase_nxt >= PHASE_LO);

            // Negated AS wins over a coincident C8M fall.
            if (bus.ncpuAS) begin
                dtack_q <= 1'b0;
                vpa_q   <= 1'b0;
            end else if (c8m_fall) begin
                dtack_q <= ~dtack_n_sync;
                vpa_q   <= ~vpa_n_sync;
            end

            timeout_q <= 1'b0;
            if (bus.ncpuAS) begin
                wd_count <= '0;
            end else if (c8m_rise && !dtack_q && !vpa_q && (wd_count != WD_LIMIT)) begin
                wd_count  <= wd_count + 8'd1;
                timeout_q <= (wd_count == WD_LAST);
            end
        end
    end

    assign bus.c8mSync      = c8m_sync;
    assign bus.c8mRise      = c8m_rise_q;
    assign bus.c8mFall      = c8m_fall_q;
    assign bus.eSync        = e_sync;
    assign bus.ePhase       = e_phase;
    assign bus.eLocked      = e_locked;
    assign bus.eRiseNext    = e_rise_next;
    assign bus.dtackSampled = dtack_q;
    assign bus.vpaSampled   = vpa_q;
    assign bus.busTimeout   = timeout_q;
endmodule

// File: tb/tb_pds_bus_sync.sv
// Self-checking bench for pds_bus_sync: a delay-line behavioural model checked every
// cycle, plus directed literal checks for reset, latency, E lock, sampling and timeout.
module tb_pds_bus_sync;
    localparam int S  = 2;
    localparam int EP = 10;
    localparam int TO = 5;

    logic clk = 1'b0;
    logic pds_reset;
    always #5 clk = ~clk;

    pds_bus_sync_if bus ();

    pds_bus_sync #(.SYNC_STAGES(S), .E_PERIOD(EP), .TIMEOUT_C8M(TO)) dut (
        .cpuClock (clk),
        .pdsReset (pds_reset),
        .bus      (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [13:0] dut_outs();
        return {bus.c8mSync, bus.c8mRise, bus.c8mFall, bus.eSync, bus.ePhase, bus.eLocked,
                bus.eRiseNext, bus.dtackSampled, bus.vpaSampled, bus.busTimeout};
    endfunction

    // Behavioural model: each synchronizer is a pure delay line; edges are seen S+1 edges late.
    logic [S+1:0] c8m_h, e_h, dt_h, vp_h;
    bit m_c8m, m_rise, m_fall, m_e, m_locked, m_rnext, m_dt, m_vp, m_to;
    int m_phase, m_cnt;

    always @(posedge clk) begin
        bit r, f, er, old_dt, old_vp;
        int old_phase;
        if (pds_reset) begin
            c8m_h = '0; e_h = '0; dt_h = '1; vp_h = '1;
            {m_c8m, m_rise, m_fall, m_e, m_locked, m_rnext, m_dt, m_vp, m_to} = '0;
            m_phase = 0;
            m_cnt   = 0;
        end else begin
            c8m_h = {c8m_h[S:0], bus.pdsC8m};
            e_h   = {e_h[S:0], bus.pdsClockE};
            dt_h  = {dt_h[S:0], bus.npdsDtack};
            vp_h  = {vp_h[S:0], bus.npdsVpa};
            r  = c8m_h[S] & ~c8m_h[S+1];
            f  = ~c8m_h[S] & c8m_h[S+1];
            er = e_h[S] & ~e_h[S+1];
            old_phase = m_phase;
            old_dt    = m_dt;
            old_vp    = m_vp;

            if (er) m_phase = 0;
            else if (r && m_phase < 15) m_phase = m_phase + 1;
            if (er) m_locked = (old_phase == EP - 1) || (old_phase == EP);
            else if (m_phase == 15) m_locked = 0;
            m_rnext = m_locked && (m_phase >= EP - 1);

            m_to = 0;
            if (bus.ncpuAS) m_cnt = 0;
            else if (r && !old_dt && !old_vp && m_cnt < TO) begin
                m_cnt = m_cnt + 1;
                m_to  = (m_cnt == TO);
            end

            if (bus.ncpuAS) begin
                m_dt = 0;
                m_vp = 0;
            end else if (f) begin
                m_dt = ~dt_h[S];
                m_vp = ~vp_h[S];
            end

            m_c8m  = c8m_h[S-1];
            m_e    = e_h[S-1];
            m_rise = r;
            m_fall = f;
        end
    end

    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en)
            check("outputs", 32'(dut_outs()),
                  32'({m_c8m, m_rise, m_fall, m_e, 4'(m_phase), m_locked, m_rnext, m_dt, m_vp, m_to}));
    end

    // Waveform generator: C8M with hi/lo lengths in cpuClocks, E advanced once per C8M period.
    int hi = 2, lo = 2, nhi = 2, nlo = 2, cnt = 0;
    int e_period = EP, e_high = 4, e_off = 0, e_pos = 0;
    bit e_run = 0;
    int rise_drv_cyc = -100;

    task automatic drive();
        logic prev;
        prev = bus.pdsC8m;
        cnt++;
        if (cnt >= hi + lo) begin
            cnt = 0;
            hi  = nhi;
            lo  = nlo;
        end
        bus.pdsC8m = (cnt < hi);
        if (bus.pdsC8m && !prev) rise_drv_cyc = cyc;
        if (e_run && cnt == e_off % (hi + lo)) begin
            e_pos++;
            if (e_pos >= e_period) e_pos = 0;
            bus.pdsClockE = (e_pos < e_high);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        drive();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int k, nr, nf, maxp, ndrop, nph9, nbad, pulses, rise_at_pulse, rise_with_pulse;
        pds_reset     = 1'b1;
        bus.pdsC8m    = 1'b0;
        bus.pdsClockE = 1'b0;
        bus.npdsDtack = 1'b1;
        bus.npdsVpa   = 1'b1;
        bus.ncpuAS    = 1'b1;

        // Reset held three cycles with all inputs toggling.
        @(negedge clk);
        chk_en = 1;
        repeat (3) begin
            @(negedge clk);
            cyc++;
            {bus.pdsC8m, bus.pdsClockE, bus.npdsDtack, bus.npdsVpa, bus.ncpuAS} = 5'($urandom);
        end
        check("reset_outputs", 32'(dut_outs()), 32'd0);
        pds_reset = 1'b0;
        bus.pdsC8m = 1'b0; bus.pdsClockE = 1'b0;
        bus.npdsDtack = 1'b1; bus.npdsVpa = 1'b1; bus.ncpuAS = 1'b1;
        cnt = 2;
        step();
        check("no_strobe_after_release", {30'd0, bus.c8mRise, bus.c8mFall}, 32'd0);

        // C8M = cpuClock/4: strobe latency and strobe count.
        for (k = 0; k < 20 && !bus.c8mRise; k++) step();
        check("first_rise_seen", 32'(bus.c8mRise), 32'd1);
        check("rise_latency", 32'(cyc - rise_drv_cyc), 32'd3);
        nr = 0; nf = 0; nbad = 0;
        repeat (40) begin
            step();
            nr += int'(bus.c8mRise);
            nf += int'(bus.c8mFall);
            if (bus.c8mRise && bus.c8mFall) nbad++;
        end
        check("rise_count_40", 32'(nr), 32'd10);
        check("fall_count_40", 32'(nf), 32'd10);
        check("rise_fall_overlap", 32'(nbad), 32'd0);

        // E period 10 (4 high / 6 low), rising together with C8M.
        e_run = 1; e_period = 10; e_high = 4; e_off = 0; e_pos = e_period - 1;
        repeat (60) step();
        maxp = 0; ndrop = 0; nph9 = 0; nbad = 0;
        repeat (60) begin
            step();
            if (int'(bus.ePhase) > maxp) maxp = int'(bus.ePhase);
            if (!bus.eLocked) ndrop++;
            if (bus.ePhase >= 4'd9) begin
                nph9++;
                if (!bus.eRiseNext) nbad++;
            end
        end
        check("e_locked", 32'(bus.eLocked), 32'd1);
        check("e_max_phase", 32'(maxp), 32'd9);
        check("lock_retained_coincident", 32'(ndrop), 32'd0);
        check("phase9_seen", 32'(nph9 > 0), 32'd1);
        check("rnext_when_phase9", 32'(nbad), 32'd0);

        // One stretched period of 13 drops the lock at its closing E rise.
        e_period = 13;
        maxp = 0;
        for (k = 0; k < 100 && bus.eLocked; k++) begin
            step();
            if (int'(bus.ePhase) > maxp) maxp = int'(bus.ePhase);
        end
        check("stretch_unlock", 32'(bus.eLocked), 32'd0);
        check("stretch_phase", 32'(maxp), 32'd12);
        e_period = 10;
        repeat (100) step();
        check("relock", 32'(bus.eLocked), 32'd1);

        // E stopped: phase saturates, lock lost.
        e_run = 0;
        bus.pdsClockE = 1'b0;
        repeat (80) step();
        check("stall_phase", 32'(bus.ePhase), 32'd15);
        check("stall_unlock", 32'(bus.eLocked), 32'd0);

        // DTACK dropped while C8M is high is captured at the next fall strobe.
        bus.ncpuAS = 1'b0;
        for (k = 0; k < 10 && cnt != 1; k++) step();
        bus.npdsDtack = 1'b0;
        for (k = 0; k < 20 && !bus.dtackSampled; k++) step();
        check("dtack_sampled", 32'(bus.dtackSampled), 32'd1);
        check("dtack_at_fall", 32'(bus.c8mFall), 32'd1);
        repeat (3) step();
        bus.ncpuAS = 1'b1;
        step();
        check("as_clear_fall", 32'(bus.c8mFall), 32'd1);
        check("as_clear_flag", 32'(bus.dtackSampled), 32'd0);

        // Watchdog: single pulse on the 5th C8M rise with AS held.
        bus.npdsDtack = 1'b1;
        repeat (4) step();
        bus.ncpuAS = 1'b0;
        nr = 0; pulses = 0; rise_at_pulse = 0; rise_with_pulse = 0;
        repeat (120) begin
            step();
            nr += int'(bus.c8mRise);
            if (bus.busTimeout) begin
                pulses++;
                rise_at_pulse   = nr;
                rise_with_pulse = int'(bus.c8mRise);
            end
        end
        check("timeout_pulses", 32'(pulses), 32'd1);
        check("timeout_rise_idx", 32'(rise_at_pulse), 32'd5);
        check("timeout_on_rise", 32'(rise_with_pulse), 32'd1);

        // Re-armed cycle terminated by VPA: no pulse.
        bus.ncpuAS = 1'b1;
        repeat (3) step();
        bus.ncpuAS = 1'b0;
        nr = 0; pulses = 0;
        repeat (120) begin
            step();
            nr += int'(bus.c8mRise);
            if (nr == 3) bus.npdsVpa = 1'b0;
            pulses += int'(bus.busTimeout);
        end
        check("vpa_no_timeout", 32'(pulses), 32'd0);
        check("vpa_sampled", 32'(bus.vpaSampled), 32'd1);
        bus.npdsVpa = 1'b1;

        // Randomized segments checked by the model every cycle.
        for (int seg = 0; seg < 40; seg++) begin
            nhi      = int'($urandom_range(1, 3));
            nlo      = int'($urandom_range(1, 3));
            e_period = int'($urandom_range(8, 13));
            e_off    = int'($urandom_range(0, 3));
            e_run    = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) begin
                pds_reset = 1'b1;
                repeat ($urandom_range(1, 3)) step();
                pds_reset = 1'b0;
            end
            repeat (75) begin
                step();
                if ($urandom_range(0, 15) == 0) bus.npdsDtack = ~bus.npdsDtack;
                if ($urandom_range(0, 15) == 0) bus.npdsVpa = ~bus.npdsVpa;
                if ($urandom_range(0, 19) == 0) bus.ncpuAS = ~bus.ncpuAS;
            end
        end

        @(negedge clk);
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
